bcd_xs3_seq: RTL and testbench
==============================

Name: bcd_xs3_seq

Overview:
Multi-digit packed-BCD to excess-3 converter. This is the encode direction that pairs with the existing xs3_bcd decoder.
- Accepts one DIGITS-wide packed BCD word through a valid/ready handshake.
- Converts one digit per clock, least-significant digit first.
- Presents the packed excess-3 result through a second valid/ready handshake.
- Flags any non-BCD digit (>9) in the word.

Parameters:
DIGITS, 4, number of BCD digits per word (>=1); data width is 4*DIGITS.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  bcd_in holds a word to convert
in_ready  output  1  block can accept a word (high only in IDLE)
bcd_in  input  4*DIGITS  packed BCD word, digit 0 = bits [3:0]
out_valid  output  1  xs3_out/err hold a completed result
out_ready  input  1  downstream accepts the result
xs3_out  output  4*DIGITS  packed excess-3 result, same digit order as bcd_in
err  output  1  at least one input digit was >9; valid with out_valid
busy  output  1  high in CONV or HOLD

Behaviour:
- Clock, reset and handshake basics
  - Single clock domain (clk).
  - Reset is synchronous and active-high (rst); it is sampled only on the clk rising edge.
  - Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Reset values (after an edge with rst=1)
  - state=IDLE, digit counter=0, xs3_out=0, err=0, out_valid=0, busy=0.
  - in_ready=1, because in_ready is decoded from state==IDLE.
- FSM states: IDLE, CONV, HOLD.
  - IDLE: in_ready=1.
    - On an input transfer: capture bcd_in into the working register, clear the counter and err, go to CONV.
    - Without a transfer, stay in IDLE.
  - CONV: in_ready=0, busy=1.
    - Each edge converts digit[counter]: result nibble = (d + 3) mod 16, written to xs3_out nibble [counter].
    - If d>9, set err (sticky for this word). Then increment the counter.
    - On the edge converting digit DIGITS-1, go to HOLD and set out_valid=1.
    - in_valid and out_ready are ignored in CONV.
  - HOLD: out_valid=1, busy=1, in_ready=0.
    - xs3_out and err hold stable until the output transfer.
    - On the output transfer: out_valid=0, busy=0, go to IDLE.
- Timing
  - Latency: out_valid rises exactly DIGITS edges after the accepting edge.
  - Earliest next acceptance is 2 edges after out_valid rises, so peak throughput is one word per DIGITS+2 cycles.
  - out_ready may already be high when out_valid rises; the transfer then occurs on the next edge.
- Arithmetic
  - 4-bit add of 3, carry discarded. Examples: 0->3, 9->C, A->D, D->0, F->2.
  - Invalid digits still produce this value, with err=1.
  - Nibbles of xs3_out not yet converted in CONV are don't-care; only the value presented with out_valid is checked.
- Boundary conditions
  - rst=1 in any state aborts the in-flight word: no out_valid for it, all outputs return to reset values.
  - rst has priority over simultaneous handshakes.
  - in_valid held high while in_ready=0: the word is not captured. The source must hold bcd_in until the transfer.
  - DIGITS=1: CONV lasts one cycle.
  - Counter width: clog2(DIGITS), minimum 1 bit.

Test Plan:
- Reset, then bcd_in=0x1234 with in_valid=1 and out_ready=1 → xs3_out=0x4567, err=0; out_valid rises exactly 4 edges after acceptance and stays high one cycle.
- Sweep every digit 0–9 in every position (e.g. 0x0000→0x3333, 0x9999→0xCCCC, 0x5678→0x89AB) → all match the (d+3) rule, err=0.
- bcd_in=0x0A05 → xs3_out=0x3D38, err=1. Next word 0x0001 → 0x3334, err=0 (err clears per word).
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with a new word → xs3_out/err stable, in_ready=0, new word not captured. When out_ready=1: one transfer, then in_ready=1, then the new word is accepted.
- Reset mid-CONV (after 2 digits) → out_valid never rises for that word, in_ready=1 after the reset edge. A subsequent word 0x4321 → 0x7654.
- Back-to-back stream of 8 words with in_valid and out_ready tied high → one word completes every 6 cycles (DIGITS=4), results in order, no drops or duplicates.

Source files
------------

// File: rtl/bcd_xs3_seq.sv
// bcd_xs3_seq: multi-digit packed-BCD to excess-3 encoder.
// A word is accepted in IDLE, converted one digit per clock (LSD first) in
// CONV, then held in HOLD until the downstream side takes it.
module bcd_xs3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   xs3_out,
  output logic                  err,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_xs3;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [3:0]    w_digit;
  logic [3:0]    w_xs3Digit;
  logic          w_digitBad;
  logic          w_inXfer;
  logic          w_outXfer;

  // Select the digit under conversion and form its excess-3 code (carry dropped).
  always_comb begin
    w_digit    = r_work[r_cnt*4 +: 4];
    w_xs3Digit = w_digit + 4'd3;
    w_digitBad = (w_digit > 4'd9);
    w_inXfer   = in_valid && (r_state == S_IDLE);
    w_outXfer  = out_ready && (r_state == S_HOLD);
  end

  // Control FSM plus working, result and error registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_xs3   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_inXfer) begin
            r_work  <= bcd_in;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_xs3[r_cnt*4 +: 4] <= w_xs3Digit;
          r_err               <= r_err | w_digitBad;
          if (r_cnt == LAST_DIGIT) begin
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (w_outXfer) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_HOLD);
    busy      = (r_state == S_CONV) || (r_state == S_HOLD);
    xs3_out   = r_xs3;
    err       = r_err;
  end

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// tb_bcd_xs3_seq: directed self-checking bench for bcd_xs3_seq with DIGITS=4.
module tb_bcd_xs3_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] bcd_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] xs3_out;
  logic         err;
  logic         busy;

  int checkCount;
  int failCount;

  bcd_xs3_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xs3_out   (xs3_out),
    .err       (err),
    .busy      (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Push one word through with out_ready high and check result, err and latency.
  task automatic applyStimulus(input string tag, input logic [W-1:0] word,
                               input logic [W-1:0] expXs3, input logic expErr);
    int lat;
    bcd_in    = word;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    checkOutput({tag, "_inReady"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    bcd_in   = '0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_xs3"}, 32'(xs3_out), 32'(expXs3));
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    step();
    checkOutput({tag, "_validDrop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_readyBack"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] streamIn  [8];
  logic [W-1:0] streamExp [8];

  initial begin
    int idx;
    int outIdx;
    int lastRise;
    int cyc;
    int seen;
    logic acc;

    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    bcd_in     = '0;
    out_ready  = 1'b0;

    $display("[TB] reset");
    step();
    step();
    checkOutput("rst_inReady",  32'(in_ready),  32'd1);
    checkOutput("rst_outValid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy",     32'(busy),      32'd0);
    checkOutput("rst_xs3",      32'(xs3_out),   32'd0);
    checkOutput("rst_err",      32'(err),       32'd0);
    rst = 1'b0;
    step();

    $display("[TB] basic and digit sweep");
    applyStimulus("w1234", 16'h1234, 16'h4567, 1'b0);
    applyStimulus("w0000", 16'h0000, 16'h3333, 1'b0);
    applyStimulus("w9999", 16'h9999, 16'hCCCC, 1'b0);
    applyStimulus("w5678", 16'h5678, 16'h89AB, 1'b0);
    applyStimulus("w9012", 16'h9012, 16'hC345, 1'b0);
    applyStimulus("w3456", 16'h3456, 16'h6789, 1'b0);
    applyStimulus("w7890", 16'h7890, 16'hABC3, 1'b0);

    $display("[TB] invalid digits");
    applyStimulus("w0A05", 16'h0A05, 16'h3D38, 1'b1);
    applyStimulus("w0001", 16'h0001, 16'h3334, 1'b0);
    applyStimulus("wF0D0", 16'hF0D0, 16'h2303, 1'b1);

    $display("[TB] backpressure");
    bcd_in    = 16'h1111;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    bcd_in = 16'h2222;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    checkOutput("bp_outValid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_holdXs3",     32'(xs3_out),   32'h4444);
      checkOutput("bp_holdErr",     32'(err),       32'd0);
      checkOutput("bp_holdInReady", 32'(in_ready),  32'd0);
      checkOutput("bp_holdValid",   32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_xferValid",   32'(out_valid), 32'd0);
    checkOutput("bp_xferInReady", 32'(in_ready),  32'd1);
    step();
    checkOutput("bp_acceptBusy",    32'(busy),     32'd1);
    checkOutput("bp_acceptInReady", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    checkOutput("bp_secondXs3", 32'(xs3_out), 32'h5555);
    step();

    $display("[TB] reset during conversion");
    bcd_in   = 16'h9876;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("midRst_busyBefore", 32'(busy), 32'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    checkOutput("midRst_inReady",  32'(in_ready),  32'd1);
    checkOutput("midRst_busy",     32'(busy),      32'd0);
    checkOutput("midRst_outValid", 32'(out_valid), 32'd0);
    checkOutput("midRst_xs3",      32'(xs3_out),   32'd0);
    checkOutput("midRst_err",      32'(err),       32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    checkOutput("midRst_noValid", 32'(seen), 32'd0);
    applyStimulus("w4321", 16'h4321, 16'h7654, 1'b0);

    $display("[TB] back-to-back stream");
    streamIn[0] = 16'h0123; streamExp[0] = 16'h3456;
    streamIn[1] = 16'h4567; streamExp[1] = 16'h789A;
    streamIn[2] = 16'h8901; streamExp[2] = 16'hBC34;
    streamIn[3] = 16'h2345; streamExp[3] = 16'h5678;
    streamIn[4] = 16'h6789; streamExp[4] = 16'h9ABC;
    streamIn[5] = 16'h9876; streamExp[5] = 16'hCBA9;
    streamIn[6] = 16'h5432; streamExp[6] = 16'h8765;
    streamIn[7] = 16'h1098; streamExp[7] = 16'h43CB;
    idx       = 0;
    outIdx    = 0;
    lastRise  = 0;
    cyc       = 0;
    bcd_in    = streamIn[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (outIdx < 8 && cyc < 200) begin
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) bcd_in = streamIn[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        checkOutput("stream_xs3", 32'(xs3_out), 32'(streamExp[outIdx]));
        checkOutput("stream_err", 32'(err), 32'd0);
        if (outIdx > 0) checkOutput("stream_period", 32'(cyc - lastRise), 32'd6);
        lastRise = cyc;
        outIdx++;
      end
    end
    checkOutput("stream_count", 32'(outIdx), 32'd8);
    in_valid = 1'b0;
    step();
    step();
    checkOutput("stream_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
